hamming_secded_decoder_pipe: RTL

- Parametrised, pipelined SECDED (extended Hamming) decoder; successor to the fixed 15/11 combinational decoder.
- Accepts a DATA_W-bit payload protected by PAR_W Hamming parity bits plus one overall parity bit over a valid/ready stream.
- Corrects single-bit errors and detects double-bit errors; detect-only mode available.
- Keeps saturating corrected/uncorrectable event counters for the status block.

---
 rtl/hamming_secded_decoder_pipe_if.sv | 33 +++
 rtl/hamming_secded_decoder_pipe.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_decoder_pipe_if.sv
// Stream and status bundle for the pipelined SECDED decoder.
// The master drives codewords and consumes results. The slave is the decoder.
interface hamming_secded_decoder_pipe_if #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W+PAR_W:0]    in_code;
    logic                     correct_en;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [PAR_W-1:0]         out_syndrome;
    logic                     out_corr;
    logic                     out_uncorr;
    logic                     clr_cnt;
    logic [CNT_W-1:0]         corr_cnt;
    logic [CNT_W-1:0]         uncorr_cnt;

    modport master (
        output in_valid, in_code, correct_en, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_syndrome, out_corr,
               out_uncorr, corr_cnt, uncorr_cnt
    );

    modport slave (
        input  in_valid, in_code, correct_en, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_syndrome, out_corr,
               out_uncorr, corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with a valid/ready stream.
// Stage 1 captures the codeword with its syndrome and overall parity.
// Stage 2 classifies the error, optionally corrects it and extracts the payload.
// Saturating event counters track corrected and uncorrectable results.
module hamming_secded_decoder_pipe #(
    parameter int DATA_W = 11,
    parameter int PAR_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic clk,
    input  logic rst,
    hamming_secded_decoder_pipe_if.slave bus
);
    localparam int N = DATA_W + PAR_W;
    localparam logic [PAR_W:0]   N_L     = (PAR_W+1)'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (2**PAR_W < DATA_W + PAR_W + 1) begin : g_bad_par
        $error("PAR_W too small to cover DATA_W+PAR_W+1 positions");
    end

    // Codeword bit index holding payload bit k: the k-th non-power-of-two position.
    function automatic int data_bit(input int k);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == k) res = p - 1;
                cnt++;
            end
        end
        return res;
    endfunction

    logic             w_en;
    logic [PAR_W-1:0] w_syn;
    logic             w_perr;

    logic             r_s1_valid;
    logic [N-1:0]     r_s1_code;
    logic [PAR_W-1:0] r_s1_syn;
    logic             r_s1_perr;
    logic             r_s1_cen;

    logic             w_syn_zero;
    logic             w_syn_in_range;
    logic             w_single;
    logic             w_corr;
    logic             w_uncorr;
    logic [N-1:0]     w_fixed;
    logic [DATA_W-1:0] w_data;

    logic              r_s2_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [PAR_W-1:0]  r_out_syn;
    logic              r_out_corr;
    logic              r_out_uncorr;
    logic [CNT_W-1:0]  r_corr_cnt;
    logic [CNT_W-1:0]  r_uncorr_cnt;
    logic              w_out_xfer;

    // Both stages advance together whenever the output slot is free or draining.
    assign w_en       = !r_s2_valid || bus.out_ready;
    assign w_out_xfer = r_s2_valid && bus.out_ready;

    // Syndrome is the XOR of the positions of all set bits in the Hamming field.
    always_comb begin
        w_syn = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_code[i]) w_syn = w_syn ^ PAR_W'(i + 1);
        end
    end

    assign w_perr = ^bus.in_code;

    // Stage 1: capture codeword and its checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_code  <= '0;
            r_s1_syn   <= '0;
            r_s1_perr  <= 1'b0;
            r_s1_cen   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_code <= bus.in_code[N-1:0];
                r_s1_syn  <= w_syn;
                r_s1_perr <= w_perr;
                r_s1_cen  <= bus.correct_en;
            end
        end
    end

    assign w_syn_zero     = (r_s1_syn == '0);
    assign w_syn_in_range = ({1'b0, r_s1_syn} <= N_L);
    assign w_single       = !w_syn_zero && r_s1_perr && w_syn_in_range;
    assign w_corr         = r_s1_perr && (w_syn_zero || w_syn_in_range);
    assign w_uncorr       = !w_syn_zero && (!r_s1_perr || !w_syn_in_range);

    // Flip the bit the syndrome points at, only for a correctable single error.
    always_comb begin
        w_fixed = r_s1_code;
        for (int i = 0; i < N; i++) begin
            if (w_single && r_s1_cen && (r_s1_syn == PAR_W'(i + 1))) begin
                w_fixed[i] = ~r_s1_code[i];
            end
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_extract
        assign w_data[k] = w_fixed[data_bit(k)];
    end

    // Stage 2: register the decoded result; it holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_out_data   <= '0;
            r_out_syn    <= '0;
            r_out_corr   <= 1'b0;
            r_out_uncorr <= 1'b0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data   <= w_data;
                r_out_syn    <= r_s1_syn;
                r_out_corr   <= w_corr;
                r_out_uncorr <= w_uncorr;
            end
        end
    end

    // Saturating event counters; a clear wins over a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_out_corr && (r_corr_cnt != CNT_MAX))
                r_corr_cnt <= r_corr_cnt + 1'b1;
            if (r_out_uncorr && (r_uncorr_cnt != CNT_MAX))
                r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign bus.in_ready     = w_en;
    assign bus.out_valid    = r_s2_valid;
    assign bus.out_data     = r_out_data;
    assign bus.out_syndrome = r_out_syn;
    assign bus.out_corr     = r_out_corr;
    assign bus.out_uncorr   = r_out_uncorr;
    assign bus.corr_cnt     = r_corr_cnt;
    assign bus.uncorr_cnt   = r_uncorr_cnt;
endmodule
